// File: rtl/psram_responder.sv
// ---------------------------------------------------------------------------
// psram_responder
//
// Responder side of the PSRAM controller request interface. Requests from the
// core-side handshake are served from an internal 16-bit word array; there are
// no external memory pins. Each accepted request occupies the block for exactly
// LATENCY cycles (busy high), after which it returns to IDLE for one cycle.
//
// Parameters
//   ADDR_WIDTH : low address bits used to index storage (2^ADDR_WIDTH words)
//   LATENCY    : cycles from acceptance to completion, 1..15
//
// Ports
//   clk             : single clock, rising edge
//   reset           : asynchronous, active-high reset
//   addr            : 22-bit word address (upper bits alias)
//   write_en        : write request
//   data_in         : write data
//   write_high_byte : byte enable for data_in[15:8]
//   write_low_byte  : byte enable for data_in[7:0]
//   read_en         : read request
//   read_avail      : one-cycle pulse, data_out valid
//   data_out        : read data, held until the next read completes
//   busy            : request in flight, new requests are dropped
//   req_dropped     : sticky flag, a request was discarded
// ---------------------------------------------------------------------------
module psram_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [21:0] addr,
    input  logic        write_en,
    input  logic [15:0] data_in,
    input  logic        write_high_byte,
    input  logic        write_low_byte,
    input  logic        read_en,
    output logic        read_avail,
    output logic [15:0] data_out,
    output logic        busy,
    output logic        req_dropped
);

    localparam int              CW        = $clog2(LATENCY + 1);
    localparam logic [CW-1:0]   CNT_LOAD  = CW'(LATENCY - 1);
    localparam logic [CW-1:0]   CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam int              DEPTH     = 1 << ADDR_WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t                  r_state;
    logic [CW-1:0]           r_cnt;
    logic                    r_is_write;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [15:0]             r_data;
    logic                    r_be_hi;
    logic                    r_be_lo;
    logic                    r_read_avail;
    logic [15:0]             r_data_out;
    logic                    r_busy;
    logic                    r_req_dropped;
    logic [15:0]             r_mem [0:DEPTH-1];

    state_t                  w_state_next;
    logic [CW-1:0]           w_cnt_next;
    logic                    w_accept;
    logic                    w_drop;
    logic                    w_commit;
    logic                    w_is_write_next;
    logic [ADDR_WIDTH-1:0]   w_addr_next;
    logic                    w_rd_done_next;
    logic                    w_addr_unused;

    // Upper address bits alias; they are intentionally not decoded.
    assign w_addr_unused = ^addr[21:ADDR_WIDTH];

    // Next-state, counter and request-accept/drop decisions.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_drop       = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (write_en || read_en) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_ACCESS;
                    w_cnt_next   = CNT_LOAD;
                    // Write wins a simultaneous request; the read is lost.
                    w_drop       = write_en && read_en;
                end else begin
                    w_accept     = 1'b0;
                end
            end
            ST_ACCESS: begin
                w_drop = write_en || read_en;
                if (r_cnt == CNT_ZERO) begin
                    w_commit     = r_is_write;
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next   = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = CNT_ZERO;
            end
        endcase
    end

    // Look one cycle ahead so read_avail/data_out are registered and line up
    // with the completing cycle (counter==0), including LATENCY=1.
    always_comb begin
        w_is_write_next = r_is_write;
        w_addr_next     = r_addr;
        if (w_accept) begin
            w_is_write_next = write_en;
            w_addr_next     = addr[ADDR_WIDTH-1:0];
        end else begin
            w_is_write_next = r_is_write;
        end
        w_rd_done_next = (w_state_next == ST_ACCESS) && (w_cnt_next == CNT_ZERO) &&
                         !w_is_write_next;
    end

    // Control state, captured request and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= CNT_ZERO;
            r_is_write    <= 1'b0;
            r_addr        <= {ADDR_WIDTH{1'b0}};
            r_data        <= 16'h0000;
            r_be_hi       <= 1'b0;
            r_be_lo       <= 1'b0;
            r_read_avail  <= 1'b0;
            r_data_out    <= 16'h0000;
            r_busy        <= 1'b0;
            r_req_dropped <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_busy       <= (w_state_next == ST_ACCESS);
            r_read_avail <= w_rd_done_next;
            r_is_write   <= w_is_write_next;
            r_addr       <= w_addr_next;
            if (w_accept) begin
                r_data  <= data_in;
                r_be_hi <= write_high_byte;
                r_be_lo <= write_low_byte;
            end
            if (w_rd_done_next) begin
                r_data_out <= r_mem[w_addr_next];
            end
            if (w_drop) begin
                r_req_dropped <= 1'b1;
            end
        end
    end

    // Storage: not reset; a write commits at the end of its completing cycle.
    // A reset during ACCESS forces IDLE, so an aborted write never commits.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            if (r_be_hi) begin
                r_mem[r_addr][15:8] <= r_data[15:8];
            end
            if (r_be_lo) begin
                r_mem[r_addr][7:0] <= r_data[7:0];
            end
        end
    end

    assign read_avail  = r_read_avail;
    assign data_out    = r_data_out;
    assign busy        = r_busy;
    assign req_dropped = r_req_dropped;

endmodule
